wbu_trap_csr: RTL and testbench

- Next-generation writeback/commit stage. Sits after the EXU and owns the machine-mode CSR file.
- Drives the GPR write port and takes precise synchronous exceptions with an explicit cause and mtval.
- Takes machine timer and external interrupts at instruction boundaries, supporting direct or vectored mtvec.
- Issues one registered control-flow redirect (cs_flush/cs_dnpc) to the control unit, plus icache and TLB flush strobes.

---
 rtl/wbu_trap_csr_pkg.sv | 43 ++++
 rtl/wbu_trap_csr_counters.sv | 43 ++++
 rtl/wbu_trap_csr.sv | 201 ++++++++++++++++++++
 tb/tb_wbu_trap_csr.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbu_trap_csr_pkg.sv
// Shared definitions for the writeback/trap/CSR stage: CSR addresses,
// trap codes, mstatus bit positions and the commit classification.
package wbu_trap_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_SATP      = 12'h180;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    localparam logic [3:0] IRQ_CODE_TIMER = 4'd7;
    localparam logic [3:0] IRQ_CODE_EXT   = 4'd11;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;
    localparam int unsigned MIE_MTIE     = 7;
    localparam int unsigned MIE_MEIE     = 11;

    typedef enum logic [2:0] {
        CC_NONE,
        CC_PLAIN,
        CC_EXC,
        CC_RET,
        CC_CSR,
        CC_FENCEI,
        CC_IRQ
    } commit_class_t;

    function automatic logic [31:0] mtvec_legalize(input logic [31:0] v, input logic vec_en);
        return {v[31:2], 1'b0, v[0] & vec_en};
    endfunction

endpackage

// File: rtl/wbu_trap_csr_counters.sv
// 64-bit mcycle/minstret pair; a CSR write to one half replaces it and
// suppresses that counter's increment for the cycle.
module wbu_trap_csr_counters
    import wbu_trap_csr_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        i_wen,
    input  logic [11:0] i_waddr,
    input  logic [31:0] i_wdata,
    input  logic        i_instret,
    output logic [63:0] o_mcycle,
    output logic [63:0] o_minstret
);

    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            if (i_wen && i_waddr == CSR_MCYCLE)
                r_mcycle[31:0] <= i_wdata;
            else if (i_wen && i_waddr == CSR_MCYCLEH)
                r_mcycle[63:32] <= i_wdata;
            else
                r_mcycle <= r_mcycle + 64'd1;

            if (i_wen && i_waddr == CSR_MINSTRET)
                r_minstret[31:0] <= i_wdata;
            else if (i_wen && i_waddr == CSR_MINSTRETH)
                r_minstret[63:32] <= i_wdata;
            else if (i_instret)
                r_minstret <= r_minstret + 64'd1;
        end
    end

    assign o_mcycle   = r_mcycle;
    assign o_minstret = r_minstret;

endmodule

// File: rtl/wbu_trap_csr.sv
// Writeback/commit stage owning the machine-mode CSR file, traps and redirects.
// Optional mcycle/minstret counters are built when WBU_COUNTERS_EN is defined.
module wbu_trap_csr
    import wbu_trap_csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0,
    parameter logic [31:0] MVENDORID   = 32'h79737978,
    parameter logic [31:0] MARCHID     = 32'h015fdeeb,
    parameter int          VECTOR_EN   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_dnpc,
    input  logic [4:0]  in_gpr_waddr,
    input  logic [31:0] in_gpr_wdata,
    input  logic        in_csr_wen,
    input  logic [11:0] in_csr_waddr,
    input  logic [31:0] in_csr_wdata,
    input  logic        in_exc,
    input  logic [3:0]  in_exc_cause,
    input  logic [31:0] in_exc_tval,
    input  logic        in_ret,
    input  logic        in_fencei,
    input  logic        irq_timer,
    input  logic        irq_ext,
    output logic        gpr_wen,
    output logic [4:0]  gpr_waddr,
    output logic [31:0] gpr_wdata,
    input  logic [11:0] csr_raddr,
    output logic [31:0] csr_rdata,
    output logic        cs_flush,
    output logic [31:0] cs_dnpc,
    output logic        flush_icache,
    output logic        flush_tlb,
    output logic [31:0] csr_satp
);

    localparam logic W_VEC_EN = (VECTOR_EN != 0);

    logic        r_mie, r_mpie, r_meie, r_mtie;
    logic [31:0] r_mtvec, r_mepc, r_mcause, r_mtval, r_mscratch, r_satp;
    logic        r_cs_flush, r_flush_tlb, r_flush_icache;
    logic [31:0] r_cs_dnpc;

    commit_class_t w_class;
    logic          w_irq, w_redirect;
    logic [3:0]    w_irq_code;
    logic [31:0]   w_base, w_target, w_pc4;

    assign in_ready  = 1'b1;
    assign gpr_wen   = in_valid & ~in_exc & (in_gpr_waddr != 5'd0);
    assign gpr_waddr = in_gpr_waddr;
    assign gpr_wdata = in_gpr_wdata;

    assign w_irq      = r_mie & ((irq_ext & r_meie) | (irq_timer & r_mtie));
    assign w_irq_code = (irq_ext & r_meie) ? IRQ_CODE_EXT : IRQ_CODE_TIMER;
    assign w_base     = {r_mtvec[31:2], 2'b00};
    assign w_pc4      = in_pc + 32'd4;

    always_comb begin
        w_class  = CC_NONE;
        w_target = '0;
        if (in_valid) begin
            if (in_exc) begin
                w_class  = CC_EXC;
                w_target = w_base;
            end else if (in_ret) begin
                w_class  = CC_RET;
                w_target = r_mepc;
            end else if (in_csr_wen) begin
                w_class  = CC_CSR;
                w_target = w_pc4;
            end else if (in_fencei) begin
                w_class  = CC_FENCEI;
                w_target = w_pc4;
            end else if (w_irq) begin
                w_class  = CC_IRQ;
                w_target = r_mtvec[0] ? (w_base + {26'd0, w_irq_code, 2'b00}) : w_base;
            end else begin
                w_class  = CC_PLAIN;
            end
        end
    end

    assign w_redirect = (w_class != CC_NONE) && (w_class != CC_PLAIN);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mie          <= 1'b0;
            r_mpie         <= 1'b0;
            r_meie         <= 1'b0;
            r_mtie         <= 1'b0;
            r_mtvec        <= mtvec_legalize(MTVEC_RESET, W_VEC_EN);
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_mtval        <= '0;
            r_mscratch     <= '0;
            r_satp         <= '0;
            r_cs_flush     <= 1'b0;
            r_cs_dnpc      <= '0;
            r_flush_tlb    <= 1'b0;
            r_flush_icache <= 1'b0;
        end else begin
            case (w_class)
                CC_EXC: begin
                    r_mepc   <= in_pc & 32'hFFFF_FFFC;
                    r_mcause <= {28'd0, in_exc_cause};
                    r_mtval  <= in_exc_tval;
                    r_mpie   <= r_mie;
                    r_mie    <= 1'b0;
                end
                CC_RET: begin
                    r_mie  <= r_mpie;
                    r_mpie <= 1'b1;
                end
                // The interrupted instruction has retired, so resume at its dnpc.
                CC_IRQ: begin
                    r_mepc   <= in_dnpc & 32'hFFFF_FFFC;
                    r_mcause <= {1'b1, 27'd0, w_irq_code};
                    r_mpie   <= r_mie;
                    r_mie    <= 1'b0;
                end
                CC_CSR: begin
                    case (in_csr_waddr)
                        CSR_MSTATUS: begin
                            r_mie  <= in_csr_wdata[MSTATUS_MIE];
                            r_mpie <= in_csr_wdata[MSTATUS_MPIE];
                        end
                        CSR_MIE: begin
                            r_meie <= in_csr_wdata[MIE_MEIE];
                            r_mtie <= in_csr_wdata[MIE_MTIE];
                        end
                        CSR_MTVEC:    r_mtvec    <= mtvec_legalize(in_csr_wdata, W_VEC_EN);
                        CSR_MEPC:     r_mepc     <= in_csr_wdata & 32'hFFFF_FFFC;
                        CSR_MCAUSE:   r_mcause   <= in_csr_wdata;
                        CSR_MTVAL:    r_mtval    <= in_csr_wdata;
                        CSR_MSCRATCH: r_mscratch <= in_csr_wdata;
                        CSR_SATP:     r_satp     <= in_csr_wdata;
                        default: ;
                    endcase
                end
                default: ;
            endcase

            r_cs_flush     <= w_redirect;
            r_flush_tlb    <= (w_class == CC_CSR) && (in_csr_waddr == CSR_SATP);
            r_flush_icache <= (w_class == CC_FENCEI);
            if (w_redirect)
                r_cs_dnpc <= w_target;
        end
    end

`ifdef WBU_COUNTERS_EN
    logic [63:0] w_mcycle, w_minstret;

    wbu_trap_csr_counters u_counters (
        .clock      (clock),
        .reset      (reset),
        .i_wen      (w_class == CC_CSR),
        .i_waddr    (in_csr_waddr),
        .i_wdata    (in_csr_wdata),
        .i_instret  (in_valid & ~in_exc),
        .o_mcycle   (w_mcycle),
        .o_minstret (w_minstret)
    );
`endif

    always_comb begin
        csr_rdata = '0;
        case (csr_raddr)
            CSR_MSTATUS:   csr_rdata = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie, 3'd0};
            CSR_MIE:       csr_rdata = {20'd0, r_meie, 3'd0, r_mtie, 7'd0};
            CSR_MIP:       csr_rdata = {20'd0, irq_ext, 3'd0, irq_timer, 7'd0};
            CSR_MTVEC:     csr_rdata = r_mtvec;
            CSR_MEPC:      csr_rdata = r_mepc;
            CSR_MCAUSE:    csr_rdata = r_mcause;
            CSR_MTVAL:     csr_rdata = r_mtval;
            CSR_MSCRATCH:  csr_rdata = r_mscratch;
            CSR_SATP:      csr_rdata = r_satp;
            CSR_MVENDORID: csr_rdata = MVENDORID;
            CSR_MARCHID:   csr_rdata = MARCHID;
`ifdef WBU_COUNTERS_EN
            CSR_MCYCLE:    csr_rdata = w_mcycle[31:0];
            CSR_MCYCLEH:   csr_rdata = w_mcycle[63:32];
            CSR_MINSTRET:  csr_rdata = w_minstret[31:0];
            CSR_MINSTRETH: csr_rdata = w_minstret[63:32];
`endif
            default:       csr_rdata = '0;
        endcase
    end

    assign cs_flush     = r_cs_flush;
    assign cs_dnpc      = r_cs_dnpc;
    assign flush_tlb    = r_flush_tlb;
    assign flush_icache = r_flush_icache;
    assign csr_satp     = r_satp;

endmodule

// File: tb/tb_wbu_trap_csr.sv
// Bench for wbu_trap_csr: redirect scoreboard plus direct CSR/GPR checks.
`timescale 1ns/1ps
module tb_wbu_trap_csr;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_dnpc;
    logic [4:0]  in_gpr_waddr;
    logic [31:0] in_gpr_wdata;
    logic        in_csr_wen;
    logic [11:0] in_csr_waddr;
    logic [31:0] in_csr_wdata;
    logic        in_exc;
    logic [3:0]  in_exc_cause;
    logic [31:0] in_exc_tval;
    logic        in_ret, in_fencei;
    logic        irq_timer, irq_ext;
    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        cs_flush;
    logic [31:0] cs_dnpc;
    logic        flush_icache, flush_tlb;
    logic [31:0] csr_satp;

    wbu_trap_csr #(
        .MTVEC_RESET (32'h0),
        .MVENDORID   (32'h79737978),
        .MARCHID     (32'h015fdeeb),
        .VECTOR_EN   (1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_dnpc      (in_dnpc),
        .in_gpr_waddr (in_gpr_waddr),
        .in_gpr_wdata (in_gpr_wdata),
        .in_csr_wen   (in_csr_wen),
        .in_csr_waddr (in_csr_waddr),
        .in_csr_wdata (in_csr_wdata),
        .in_exc       (in_exc),
        .in_exc_cause (in_exc_cause),
        .in_exc_tval  (in_exc_tval),
        .in_ret       (in_ret),
        .in_fencei    (in_fencei),
        .irq_timer    (irq_timer),
        .irq_ext      (irq_ext),
        .gpr_wen      (gpr_wen),
        .gpr_waddr    (gpr_waddr),
        .gpr_wdata    (gpr_wdata),
        .csr_raddr    (csr_raddr),
        .csr_rdata    (csr_rdata),
        .cs_flush     (cs_flush),
        .cs_dnpc      (cs_dnpc),
        .flush_icache (flush_icache),
        .flush_tlb    (flush_tlb),
        .csr_satp     (csr_satp)
    );

    always #10 clock = ~clock;

    typedef struct packed {
        logic        flush;
        logic        tlb;
        logic        ic;
        logic [31:0] dnpc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Redirect outputs are registered: the entry pushed for a commit is
    // compared just after the following rising edge.
    always @(posedge clock) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("cs_flush", {31'd0, cs_flush}, {31'd0, e.flush});
            chk("flush_tlb", {31'd0, flush_tlb}, {31'd0, e.tlb});
            chk("flush_icache", {31'd0, flush_icache}, {31'd0, e.ic});
            if (e.flush)
                chk("cs_dnpc", cs_dnpc, e.dnpc);
        end
    end

    task automatic clr();
        in_valid = 0; in_pc = '0; in_dnpc = '0; in_gpr_waddr = '0; in_gpr_wdata = '0;
        in_csr_wen = 0; in_csr_waddr = '0; in_csr_wdata = '0;
        in_exc = 0; in_exc_cause = '0; in_exc_tval = '0; in_ret = 0; in_fencei = 0;
    endtask

    task automatic fire(input logic f, input logic t, input logic ic, input logic [31:0] d);
        sb.push_back('{flush: f, tlb: t, ic: ic, dnpc: d});
        @(posedge clock);
        #2;
        clr();
    endtask

    task automatic idle();
        clr();
        fire(0, 0, 0, '0);
    endtask

    task automatic csrw(input logic [31:0] pc, input logic [11:0] a, input logic [31:0] d, input logic t);
        clr();
        in_valid = 1; in_pc = pc; in_dnpc = pc + 32'd4;
        in_csr_wen = 1; in_csr_waddr = a; in_csr_wdata = d;
        fire(1, t, 0, pc + 32'd4);
    endtask

    task automatic plain(input logic [31:0] pc, input logic [31:0] dnpc, input logic [4:0] rd,
                         input logic [31:0] wd, input logic f, input logic [31:0] d);
        clr();
        in_valid = 1; in_pc = pc; in_dnpc = dnpc; in_gpr_waddr = rd; in_gpr_wdata = wd;
        fire(f, 0, 0, d);
    endtask

    task automatic mret(input logic [31:0] d);
        clr();
        in_valid = 1; in_ret = 1; in_pc = 32'h0000_0900; in_dnpc = 32'h0000_0904;
        fire(1, 0, 0, d);
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_raddr = a;
        #1;
        chk(tag, csr_rdata, exp);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        reset = 1; irq_timer = 0; irq_ext = 0; csr_raddr = '0;
        repeat (3) @(posedge clock);
        #2;
        chk("rst_cs_flush", {31'd0, cs_flush}, 32'd0);
        chk("rst_flush_tlb", {31'd0, flush_tlb}, 32'd0);
        chk("rst_flush_icache", {31'd0, flush_icache}, 32'd0);
        chk("rst_gpr_wen", {31'd0, gpr_wen}, 32'd0);
        chk("in_ready", {31'd0, in_ready}, 32'd1);
        rd("rst_mstatus", 12'h300, 32'h0000_1800);
        rd("rst_mtvec", 12'h305, 32'h0);
        rd("rst_mie", 12'h304, 32'h0);
        rd("rst_satp", 12'h180, 32'h0);
        rd("mvendorid", 12'hF11, 32'h79737978);
        rd("marchid", 12'hF12, 32'h015fdeeb);

        // Exception commit while reset is still asserted: reset wins.
        in_valid = 1; in_exc = 1; in_exc_cause = 4'd2; in_pc = 32'h40;
        fire(0, 0, 0, '0);
        reset = 0;
        idle();
        rd("rst_commit_mepc", 12'h341, 32'h0);
        rd("rst_commit_mcause", 12'h342, 32'h0);

        // Exception redirect
        csrw(32'h0000_1000, 12'h305, 32'h8000_0100, 0);
        csrw(32'h0000_1004, 12'h300, 32'h0000_0008, 0);
        rd("mstatus_mie_set", 12'h300, 32'h0000_1808);
        in_valid = 1; in_exc = 1; in_exc_cause = 4'd11; in_exc_tval = 32'h0000_DEAD;
        in_pc = 32'h8000_0010; in_dnpc = 32'h8000_0014; in_gpr_waddr = 5'd5; in_gpr_wdata = 32'h77;
        #1;
        chk("exc_gpr_wen", {31'd0, gpr_wen}, 32'd0);
        fire(1, 0, 0, 32'h8000_0100);
        rd("exc_mepc", 12'h341, 32'h8000_0010);
        rd("exc_mcause", 12'h342, 32'd11);
        rd("exc_mtval", 12'h343, 32'h0000_DEAD);
        rd("exc_mstatus", 12'h300, 32'h0000_1880);

        // mret
        csrw(32'h0000_1008, 12'h341, 32'h8000_0016, 0);
        rd("mepc_lsb_masked", 12'h341, 32'h8000_0014);
        mret(32'h8000_0014);
        rd("mret_mstatus", 12'h300, 32'h0000_1888);

        // Vectored timer interrupt, first blocked by a CSR write
        csrw(32'h0000_2000, 12'h305, 32'h8000_0101, 0);
        csrw(32'h0000_2004, 12'h304, 32'hFFFF_FFFF, 0);
        rd("mie_mask", 12'h304, 32'h0000_0880);
        irq_timer = 1;
        idle();
        rd("mip_timer", 12'h344, 32'h0000_0080);
        rd("idle_no_trap_mcause", 12'h342, 32'd11);
        csrw(32'h0000_0300, 12'h340, 32'h0000_1234, 0);
        rd("mscratch", 12'h340, 32'h0000_1234);
        rd("blocked_mcause", 12'h342, 32'd11);
        in_valid = 1; in_pc = 32'h8000_0200; in_dnpc = 32'h8000_0204;
        in_gpr_waddr = 5'd5; in_gpr_wdata = 32'h55;
        #1;
        chk("irq_gpr_wen", {31'd0, gpr_wen}, 32'd1);
        chk("irq_gpr_waddr", {27'd0, gpr_waddr}, 32'd5);
        chk("irq_gpr_wdata", gpr_wdata, 32'h55);
        fire(1, 0, 0, 32'h8000_011C);
        rd("tmr_mcause", 12'h342, 32'h8000_0007);
        rd("tmr_mepc", 12'h341, 32'h8000_0204);
        rd("tmr_mstatus", 12'h300, 32'h0000_1880);

        // External beats timer
        mret(32'h8000_0204);
        irq_ext = 1;
        plain(32'h0000_0400, 32'h0000_0404, 5'd6, 32'h66, 1, 32'h8000_012C);
        rd("ext_mcause", 12'h342, 32'h8000_000B);
        rd("ext_mepc", 12'h341, 32'h0000_0404);
        rd("mip_both", 12'h344, 32'h0000_0880);

        // fence.i with interrupts pending: no trap, icache flush
        mret(32'h0000_0404);
        in_valid = 1; in_fencei = 1; in_pc = 32'h0000_0500; in_dnpc = 32'h0000_0504;
        fire(1, 0, 1, 32'h0000_0504);
        rd("fencei_mcause", 12'h342, 32'h8000_000B);
        irq_timer = 0; irq_ext = 0;
        idle();

        // satp write
        csrw(32'h0000_0600, 12'h180, 32'h8008_0000, 1);
        chk("csr_satp", csr_satp, 32'h8008_0000);

        // Plain commit to x0, no interrupts
        in_valid = 1; in_pc = 32'h700; in_dnpc = 32'h704; in_gpr_waddr = 5'd0; in_gpr_wdata = 32'h99;
        #1;
        chk("x0_gpr_wen", {31'd0, gpr_wen}, 32'd0);
        fire(0, 0, 0, '0);

        // Unknown CSR, mtvec legalisation
        csrw(32'h0000_0800, 12'h7C0, 32'hFFFF_FFFF, 0);
        rd("unknown_csr", 12'h7C0, 32'h0);
        csrw(32'h0000_0804, 12'h305, 32'h8000_0103, 0);
        rd("mtvec_bit1", 12'h305, 32'h8000_0101);

`ifdef WBU_COUNTERS_EN
        csrw(32'h0000_0A00, 12'hB00, 32'hFFFF_FFFF, 0);
        csrw(32'h0000_0A04, 12'hB80, 32'hFFFF_FFFF, 0);
        rd("mcycle_lo_written", 12'hB00, 32'hFFFF_FFFF);
        rd("mcycleh_written", 12'hB80, 32'hFFFF_FFFF);
        idle();
        rd("mcycle_wrap_lo", 12'hB00, 32'h0);
        rd("mcycle_wrap_hi", 12'hB80, 32'h0);
        idle();
        rd("mcycle_after_wrap", 12'hB00, 32'h1);
`else
        rd("mcycle_absent", 12'hB00, 32'h0);
        rd("minstret_absent", 12'hB02, 32'h0);
`endif

        idle();
        @(posedge clock);
        #3;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
